// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction memory and its loader.
package cpu_pkg;

    localparam int IMEM_DEPTH    = 32;
    localparam int IMEM_LOGDEPTH = 5;

    // Loader states: header parse, word payload, finished, rejected image
    typedef enum logic [1:0] {
        HEADER,
        PAYLOAD,
        DONE,
        ERROR
    } load_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler: collects four accepted bytes and
// presents the completed word in the same cycle as the fourth byte.
module byte_assembler
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;

    // Store bytes 0..2 in their little-endian lanes; byte 3 completes the word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (in_valid) begin
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= in_data;
                2'd1:    low_bytes[15:8]  <= in_data;
                2'd2:    low_bytes[23:16] <= in_data;
                default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // The top byte is taken straight from the input so the word is usable
    // in the cycle it completes; the FSM registers the result.
    assign word_valid = in_valid && (byte_cnt == 2'd3);
    assign word       = {in_data, low_bytes};

endmodule

// File: rtl/instr_loader.sv
// Program image loader: parses a length-prefixed byte stream and writes
// the payload words into the instruction RAM write port.
module instr_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH    = IMEM_DEPTH,
    parameter int LOGDEPTH = IMEM_LOGDEPTH
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                reload,
    output logic                wr_en_instr,
    output logic [31:0]         data_in_instr,
    output logic [31:0]         addr_in_instr,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_error,
    output logic [LOGDEPTH:0]   words_loaded
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    load_state_t       state;
    logic [LOGDEPTH:0] n_words;
    logic [LOGDEPTH:0] next_words;
    logic              accepting;
    logic              take_reload;
    logic              asm_valid;
    logic [31:0]       asm_word;

    // Bytes only count while an image is in progress; reload is only
    // meaningful once the image is finished or rejected, and since bytes
    // are blocked there too, a coincident byte is simply dropped.
    assign accepting   = (state == HEADER) || (state == PAYLOAD);
    assign take_reload = reload && !accepting;
    assign next_words  = words_loaded + 1'b1;

    byte_assembler u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (take_reload),
        .in_valid   (rx_valid && accepting),
        .in_data    (rx_data),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    // Load FSM with registered write port and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= HEADER;
            n_words       <= '0;
            words_loaded  <= '0;
            wr_en_instr   <= 1'b0;
            data_in_instr <= 32'd0;
            addr_in_instr <= 32'd0;
            load_busy     <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            wr_en_instr <= 1'b0;
            case (state)
                HEADER: begin
                    if (asm_valid) begin
                        if (asm_word == 32'd0) begin
                            state     <= DONE;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end else if (asm_word > DEPTH_W) begin
                            state      <= ERROR;
                            load_busy  <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            state   <= PAYLOAD;
                            n_words <= asm_word[LOGDEPTH:0];
                        end
                    end
                end
                PAYLOAD: begin
                    if (asm_valid) begin
                        wr_en_instr   <= 1'b1;
                        data_in_instr <= asm_word;
                        // Index is below DEPTH here, so its top bit is dropped
                        addr_in_instr <= {{(30-LOGDEPTH){1'b0}},
                                          words_loaded[LOGDEPTH-1:0], 2'b00};
                        words_loaded  <= next_words;
                        if (next_words == n_words) begin
                            state     <= DONE;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (take_reload) begin
                        state        <= HEADER;
                        words_loaded <= '0;
                        load_busy    <= 1'b1;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: byte streams are built as whole
// images and the expected RAM writes are derived from the stream format.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        reload = 1'b0;
    logic        wr_en_instr;
    logic [31:0] data_in_instr;
    logic [31:0] addr_in_instr;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [5:0]  words_loaded;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        logic        done;
    } wr_t;

    wr_t        got_q[$];
    logic [7:0] stim[$];
    int         byte_cyc[$];

    instr_loader dut (
        .clk           (clk),
        .rstn          (rstn),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .reload        (reload),
        .wr_en_instr   (wr_en_instr),
        .data_in_instr (data_in_instr),
        .addr_in_instr (addr_in_instr),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write-port cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en_instr === 1'b1)
            got_q.push_back('{addr_in_instr, data_in_instr, cyc, load_done});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add_word(input logic [31:0] w);
        stim.push_back(w[7:0]);
        stim.push_back(w[15:8]);
        stim.push_back(w[23:16]);
        stim.push_back(w[31:24]);
    endfunction

    // Streams stim (starting in HEADER), then checks status one cycle after
    // the last byte and the full list of writes against the image rules.
    task automatic test_image(input string name, input int max_gap);
        logic [31:0] hdr;
        logic [31:0] exp_data;
        int nfull;
        int exp_words;
        logic exp_busy, exp_done, exp_err;
        got_q.delete();
        byte_cyc.delete();
        foreach (stim[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stim[i];
            byte_cyc.push_back(cyc);
        end
        @(negedge clk);
        rx_valid = 1'b0;

        nfull = 0; exp_words = 0;
        exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
        hdr = 32'd0;
        if (stim.size() >= 4) begin
            hdr = {stim[3], stim[2], stim[1], stim[0]};
            if (hdr == 32'd0) begin
                exp_busy = 1'b0; exp_done = 1'b1;
            end else if (hdr > 32'd32) begin
                exp_busy = 1'b0; exp_err = 1'b1;
            end else begin
                nfull = (stim.size() - 4) / 4;
                if (nfull > int'(hdr)) nfull = int'(hdr);
                exp_words = nfull;
                if (nfull == int'(hdr)) begin
                    exp_busy = 1'b0; exp_done = 1'b1;
                end
            end
        end

        checks++;
        if ({load_busy, load_done, load_error} !== {exp_busy, exp_done, exp_err}) begin
            failures++;
            $display("FAIL %s flags: busy/done/err got %b%b%b want %b%b%b", name,
                     load_busy, load_done, load_error, exp_busy, exp_done, exp_err);
        end
        checks++;
        if (words_loaded !== 6'(exp_words)) begin
            failures++;
            $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, exp_words);
        end

        @(negedge clk);
        checks++;
        if (got_q.size() != nfull) begin
            failures++;
            $display("FAIL %s write count: got %0d want %0d", name, got_q.size(), nfull);
        end
        for (int k = 0; k < nfull && k < got_q.size(); k++) begin
            exp_data = {stim[4+4*k+3], stim[4+4*k+2], stim[4+4*k+1], stim[4+4*k]};
            checks++;
            if (got_q[k].addr !== 32'(4*k) || got_q[k].data !== exp_data ||
                got_q[k].cyc != byte_cyc[4+4*k+3] + 1 ||
                got_q[k].done !== (k == int'(hdr) - 1)) begin
                failures++;
                $display("FAIL %s write %0d: got addr=%h data=%h cyc=%0d done=%b want addr=%h data=%h cyc=%0d done=%b",
                         name, k, got_q[k].addr, got_q[k].data, got_q[k].cyc, got_q[k].done,
                         32'(4*k), exp_data, byte_cyc[4+4*k+3] + 1, (k == int'(hdr) - 1));
            end
        end
        if (nfull > 0) begin
            exp_data = {stim[4*nfull+3], stim[4*nfull+2], stim[4*nfull+1], stim[4*nfull]};
            checks++;
            if (wr_en_instr !== 1'b0 || data_in_instr !== exp_data ||
                addr_in_instr !== 32'(4*(nfull-1))) begin
                failures++;
                $display("FAIL %s hold: got we=%b data=%h addr=%h want we=0 data=%h addr=%h",
                         name, wr_en_instr, data_in_instr, addr_in_instr, exp_data, 32'(4*(nfull-1)));
            end
        end
    endtask

    task automatic do_reload(input logic with_byte, input logic [7:0] b);
        @(negedge clk);
        reload   = 1'b1;
        rx_valid = with_byte;
        rx_data  = b;
        @(negedge clk);
        reload   = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr_en_instr, data_in_instr, addr_in_instr, load_busy, load_done, load_error, words_loaded}
            !== {1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL reset: got we=%b data=%h addr=%h busy=%b done=%b err=%b words=%0d want 0/0/0/1/0/0/0",
                     wr_en_instr, data_in_instr, addr_in_instr, load_busy, load_done, load_error, words_loaded);
        end
        rstn = 1'b1;
    endtask

    task automatic test_two_words();
        stim.delete();
        add_word(32'd2); add_word(32'h00100093); add_word(32'h00100113);
        test_image("two_words", 2);
    endtask

    task automatic test_zero();
        do_reload(1'b0, 8'h00);
        stim.delete();
        add_word(32'd0);
        test_image("zero", 1);
    endtask

    task automatic test_overflow();
        do_reload(1'b0, 8'h00);
        stim.delete();
        add_word(32'd33); add_word($urandom); add_word($urandom);
        test_image("overflow", 1);
        do_reload(1'b0, 8'h00);
        checks++;
        if ({load_busy, load_done, load_error, words_loaded} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL overflow reload: got busy/done/err=%b%b%b words=%0d want 100 words=0",
                     load_busy, load_done, load_error, words_loaded);
        end
    endtask

    task automatic test_back_to_back();
        // already in HEADER after the overflow reload
        stim.delete();
        add_word(32'd32);
        for (int k = 0; k < 32; k++) add_word($urandom);
        test_image("back_to_back", 0);
    endtask

    task automatic test_reset_mid();
        do_reload(1'b0, 8'h00);
        stim.delete();
        add_word(32'd2); add_word($urandom);
        stim.push_back(8'h11); stim.push_back(8'h22);
        test_image("partial", 1);
        do_reload(1'b0, 8'h00);
        checks++;
        if ({load_busy, words_loaded} !== {1'b1, 6'd1}) begin
            failures++;
            $display("FAIL reload_in_payload: got busy=%b words=%0d want busy=1 words=1",
                     load_busy, words_loaded);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checks++;
        if ({load_busy, words_loaded, data_in_instr, addr_in_instr} !== {1'b1, 6'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL mid_reset: got busy=%b words=%0d data=%h addr=%h want 1/0/0/0",
                     load_busy, words_loaded, data_in_instr, addr_in_instr);
        end
        stim.delete();
        add_word(32'd1); add_word(32'hDDCCBBAA);
        test_image("after_reset", 1);
    endtask

    task automatic test_reload_collision();
        do_reload(1'b1, 8'h05);
        checks++;
        if ({load_busy, load_done, words_loaded} !== {1'b1, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL collision: got busy=%b done=%b words=%0d want 1/0/0",
                     load_busy, load_done, words_loaded);
        end
        stim.delete();
        add_word(32'd1); add_word($urandom);
        test_image("collision_next", 1);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 6; r++) begin
            do_reload(1'b0, 8'h00);
            stim.delete();
            n = $urandom_range(9, 0);
            if (n == 9) begin
                add_word(32'($urandom_range(32'h0000FFFF, 33)));
                add_word($urandom);
            end else begin
                add_word(32'(n));
                for (int k = 0; k < n; k++) add_word($urandom);
            end
            test_image("random", 2);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_reload_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
